// File: rtl/reg_write_arbiter_if.sv
// Requester-side and register-side signals of the shared-register write arbiter.
// The master modport is the requester/bench view and the slave modport is the arbiter view.
interface reg_write_arbiter_if #(
  parameter int DW   = 8,
  parameter int NREQ = 4,
  parameter int CW   = 8
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] wdata;
  logic               clr;
  logic [NREQ-1:0]    gnt;
  logic               clr_ack;
  logic               busy;
  logic               reg_ld;
  logic               reg_rst;
  logic [DW-1:0]      reg_din;
  logic [OW-1:0]      owner;
  logic [CW-1:0]      wr_count;

  modport master (
    output req, wdata, clr,
    input  gnt, clr_ack, busy, reg_ld, reg_rst, reg_din, owner, wr_count
  );

  modport slave (
    input  req, wdata, clr,
    output gnt, clr_ack, busy, reg_ld, reg_rst, reg_din, owner, wr_count
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that shares one load/clear register among NREQ requesters.
// Every output is registered and takes its value from the state being entered.
module reg_write_arbiter #(
  parameter int DW   = 8,
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_write_arbiter_if.slave   bus
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [OW-1:0] LAST = OW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR, ACK} state_t;

  state_t          state, state_next;
  logic [OW-1:0]   ptr, ptr_next;
  logic [OW-1:0]   sel, sel_next;
  logic [OW-1:0]   owner_next;
  logic [OW-1:0]   winner;
  logic            found;
  int unsigned     idx;
  logic [NREQ-1:0] gnt_next;
  logic            ld_next, rst_next, ack_next;
  logic [DW-1:0]   din_next;
  logic [CW-1:0]   cnt_next;

  // The search starts at ptr. Wrap-around is an explicit compare, so NREQ need not be a power of two.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx[OW-1:0]]) begin
        found  = 1'b1;
        winner = idx[OW-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    sel_next   = sel;
    owner_next = bus.owner;
    cnt_next   = bus.wr_count;
    din_next   = bus.reg_din;
    gnt_next   = '0;
    ld_next    = 1'b0;
    rst_next   = 1'b0;
    ack_next   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clr) begin
          state_next = CLEAR;
          rst_next   = 1'b1;
          ack_next   = 1'b1;
        end else if (found) begin
          state_next       = WRITE;
          sel_next         = winner;
          din_next         = bus.wdata[winner*DW +: DW];
          ld_next          = 1'b1;
          gnt_next[winner] = 1'b1;
        end
      end
      WRITE: begin
        ptr_next   = (sel == LAST) ? '0 : sel + OW'(1);
        owner_next = sel;
        cnt_next   = bus.wr_count + CW'(1);
        state_next = ACK;
      end
      CLEAR:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      sel          <= '0;
      bus.gnt      <= '0;
      bus.clr_ack  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.reg_ld   <= 1'b0;
      bus.reg_rst  <= 1'b0;
      bus.reg_din  <= '0;
      bus.owner    <= '0;
      bus.wr_count <= '0;
    end else begin
      state        <= state_next;
      ptr          <= ptr_next;
      sel          <= sel_next;
      bus.gnt      <= gnt_next;
      bus.clr_ack  <= ack_next;
      bus.busy     <= (state_next != IDLE);
      bus.reg_ld   <= ld_next;
      bus.reg_rst  <= rst_next;
      bus.reg_din  <= din_next;
      bus.owner    <= owner_next;
      bus.wr_count <= cnt_next;
    end
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter. A second instance with a 2-bit counter sees the same stimulus.
module tb_reg_write_arbiter;
  localparam int DW = 8;
  localparam int NREQ = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.DW(DW), .NREQ(NREQ), .CW(CW)) b();
  reg_write_arbiter_if #(.DW(DW), .NREQ(NREQ), .CW(2))  b2();

  assign b2.req   = b.req;
  assign b2.wdata = b.wdata;
  assign b2.clr   = b.clr;

  reg_write_arbiter #(.DW(DW), .NREQ(NREQ), .CW(CW)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  reg_write_arbiter #(.DW(DW), .NREQ(NREQ), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] shreg;

  // Downstream shared register: ld has priority over rst
  always @(posedge clk) begin
    if (rst)            shreg <= '0;
    else if (b.reg_ld)  shreg <= b.reg_din;
    else if (b.reg_rst) shreg <= '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int          ord[5] = '{0, 1, 2, 3, 0};
  logic [7:0]  dexp[4] = '{8'h11, 8'h33, 8'hA5, 8'hD4};
  int          w2[5] = '{1, 2, 3, 0, 1};

  initial begin
    rst = 1'b1; b.req = '0; b.clr = 1'b0; b.wdata = '0;
    tick(); tick();
    chk("rst_gnt", 32'(b.gnt), 0);
    chk("rst_clr_ack", 32'(b.clr_ack), 0);
    chk("rst_busy", 32'(b.busy), 0);
    chk("rst_reg_ld", 32'(b.reg_ld), 0);
    chk("rst_reg_rst", 32'(b.reg_rst), 0);
    chk("rst_reg_din", 32'(b.reg_din), 0);
    chk("rst_owner", 32'(b.owner), 0);
    chk("rst_wr_count", 32'(b.wr_count), 0);
    rst = 1'b0;
    tick();

    // T1 single request
    b.wdata = {8'hD4, 8'hA5, 8'h33, 8'h11};
    b.req = 4'b0100;
    tick();
    chk("t1_reg_ld", 32'(b.reg_ld), 1);
    chk("t1_gnt", 32'(b.gnt), 32'h4);
    chk("t1_reg_din", 32'(b.reg_din), 32'hA5);
    chk("t1_busy", 32'(b.busy), 1);
    b.req = '0;
    tick();
    chk("t1_ack_ld", 32'(b.reg_ld), 0);
    chk("t1_ack_gnt", 32'(b.gnt), 0);
    chk("t1_owner", 32'(b.owner), 2);
    chk("t1_wr_count", 32'(b.wr_count), 1);
    chk("t1_shreg", 32'(shreg), 32'hA5);
    tick();
    chk("t1_idle_busy", 32'(b.busy), 0);

    // T2 round robin from a fresh pointer, T6 wrap on the CW=2 instance
    rst = 1'b1; tick(); rst = 1'b0; tick();
    b.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk($sformatf("t2_gnt%0d", n), 32'(b.gnt), 32'(1) << ord[n]);
      chk($sformatf("t2_din%0d", n), 32'(b.reg_din), 32'(dexp[ord[n]]));
      chk($sformatf("t2_rst%0d", n), 32'(b.reg_rst), 0);
      tick();
      chk($sformatf("t2_owner%0d", n), 32'(b.owner), 32'(ord[n]));
      chk($sformatf("t2_cnt%0d", n), 32'(b.wr_count), 32'(n + 1));
      chk($sformatf("t6_cnt%0d", n), 32'(b2.wr_count), 32'(w2[n]));
      tick();
    end
    b.req = '0;

    // T3 clear beats a simultaneous request
    b.wdata[7:0] = 8'h7E;
    b.clr = 1'b1; b.req = 4'b0001;
    tick();
    chk("t3_reg_rst", 32'(b.reg_rst), 1);
    chk("t3_reg_ld", 32'(b.reg_ld), 0);
    chk("t3_clr_ack", 32'(b.clr_ack), 1);
    chk("t3_gnt", 32'(b.gnt), 0);
    b.clr = 1'b0;
    tick();
    chk("t3_ack_clr_ack", 32'(b.clr_ack), 0);
    chk("t3_owner", 32'(b.owner), 0);
    chk("t3_cnt", 32'(b.wr_count), 5);
    chk("t3_shreg", 32'(shreg), 0);
    tick();
    tick();
    chk("t3_gnt_after", 32'(b.gnt), 1);
    chk("t3_ld_after", 32'(b.reg_ld), 1);
    b.req = '0;
    tick();
    chk("t3_shreg_ld", 32'(shreg), 32'h7E);
    tick();

    // T4 data captured at arbitration
    b.wdata[15:8] = 8'h11;
    b.req = 4'b0010;
    tick();
    chk("t4_gnt", 32'(b.gnt), 32'h2);
    chk("t4_din", 32'(b.reg_din), 32'h11);
    b.wdata[15:8] = 8'h22;
    b.req = '0;
    tick();
    chk("t4_din_hold", 32'(b.reg_din), 32'h11);
    chk("t4_shreg", 32'(shreg), 32'h11);
    tick();

    // T5 reset at the edge that would enter WRITE
    b.req = 4'b0100; rst = 1'b1;
    tick();
    chk("t5_ld", 32'(b.reg_ld), 0);
    chk("t5_gnt", 32'(b.gnt), 0);
    chk("t5_busy", 32'(b.busy), 0);
    chk("t5_cnt", 32'(b.wr_count), 0);
    chk("t5_owner", 32'(b.owner), 0);
    rst = 1'b0; b.req = '0;
    tick();
    chk("t5_after_ld", 32'(b.reg_ld), 0);
    chk("t5_after_gnt", 32'(b.gnt), 0);

    // Pointer restarts at 0 after reset, then wraps past NREQ-1
    b.req = 4'b1010;
    tick();
    chk("ptr_reset_gnt", 32'(b.gnt), 32'h2);
    b.req = '0; tick(); tick();
    b.req = 4'b1001;
    tick();
    chk("ptr_top_gnt", 32'(b.gnt), 32'h8);
    b.req = '0; tick(); tick();
    b.req = 4'b1001;
    tick();
    chk("ptr_wrap_gnt", 32'(b.gnt), 32'h1);
    b.req = '0; tick(); tick();
    chk("ptr_wrap_cnt", 32'(b.wr_count), 3);

    // clr held high retriggers every third cycle
    b.clr = 1'b1;
    tick();
    chk("clr_hold_a", 32'(b.clr_ack), 1);
    tick();
    chk("clr_hold_b", 32'(b.clr_ack), 0);
    tick();
    chk("clr_hold_c", 32'(b.busy), 0);
    tick();
    chk("clr_hold_d", 32'(b.clr_ack), 1);
    b.clr = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
